// File: rtl/gas_pkg.sv
`default_nettype none
// ============================================================================
// Package : gas_pkg
// Brief   : Shared gas indices and FSM state encoding for the gas alarm block.
// Rev     : 1.0  initial release
// ============================================================================
package gas_pkg;

    localparam int NUM_GAS = 3;

    localparam int GAS_CO2 = 2;
    localparam int GAS_CO  = 1;
    localparam int GAS_CH4 = 0;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WARN  = 2'd1;
    localparam logic [1:0] c_ST_ALARM = 2'd2;
    localparam logic [1:0] c_ST_ACKED = 2'd3;

endpackage
`default_nettype wire

// File: rtl/gas_hit_counter.sv
`default_nettype none
// ============================================================================
// Module : gas_hit_counter
// Brief  : Window-relative saturating hit counter for one gas, with threshold event.
// Rev    : 1.0  initial release
// ============================================================================
module gas_hit_counter #(
    parameter int THRESH = 3
) (
    input  logic clk,
    input  logic arst,
    input  logic win_wrap,
    input  logic clr,
    input  logic det,
    output logic thr
);

    localparam int CNT_W = (THRESH > 0) ? $clog2(THRESH + 1) : 1;
    localparam logic [CNT_W-1:0] c_THRESH    = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] c_THRESH_M1 = CNT_W'(THRESH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The wrap cycle opens a fresh window, so only a threshold of one can fire there.
    assign thr = win_wrap ? (det && (THRESH == 1)) : (det && (cnt_q == c_THRESH_M1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (win_wrap) begin
            cnt_d = CNT_W'(det);
        end else if (det && (cnt_q < c_THRESH)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gas_alarm_controller.sv
`default_nettype none
// ============================================================================
// Module : gas_alarm_controller
// Brief  : Windowed per-gas hit counting with warn/alarm/acknowledge FSM.
// Rev    : 1.0  initial release
// ============================================================================
module gas_alarm_controller
    import gas_pkg::*;
#(
    parameter int WINDOW   = 64,
    parameter int THRESH   = 3,
    parameter int HOLD_CYC = 16
) (
    input  logic               clk,
    input  logic               arst,
    input  logic [NUM_GAS-1:0] det,
    input  logic               ack,
    output logic               alarm,
    output logic               warn,
    output logic [NUM_GAS-1:0] gas_flags,
    output logic [1:0]         state
);

    localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [WIN_W-1:0]  c_WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    logic [WIN_W-1:0]   win_cnt_q;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [1:0]         state_q, state_d;
    logic [NUM_GAS-1:0] flags_q, flags_d;
    logic               ack_armed_q, ack_armed_d;
    logic               alarm_q, warn_q;

    logic [NUM_GAS-1:0] w_thr;
    logic               w_win_wrap;
    logic               w_clr;
    logic               w_any_thr;
    logic               w_ack_ok;

    assign w_win_wrap = (win_cnt_q == c_WIN_LAST);
    assign w_any_thr  = |w_thr;
    assign w_ack_ok   = ack && ack_armed_q;

    generate
        for (genvar g = 0; g < NUM_GAS; g++) begin : g_gas
            gas_hit_counter #(
                .THRESH (THRESH)
            ) u_hit (
                .clk      (clk),
                .arst     (arst),
                .win_wrap (w_win_wrap),
                .clr      (w_clr),
                .det      (det[g]),
                .thr      (w_thr[g])
            );
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        flags_d     = flags_q | w_thr;
        hold_cnt_d  = hold_cnt_q;
        w_clr       = 1'b0;
        // Re-arm only once ack has been seen low, so a held ack cannot acknowledge twice.
        ack_armed_d = ack ? ack_armed_q : 1'b1;
        case (state_q)
            c_ST_IDLE: begin
                if (w_any_thr) begin
                    state_d = c_ST_ALARM;
                end else if (|det) begin
                    state_d = c_ST_WARN;
                end
            end
            c_ST_WARN: begin
                if (w_any_thr) begin
                    state_d = c_ST_ALARM;
                end else if (w_win_wrap && (det == '0)) begin
                    // Counters reload from det on the wrap, so det==0 means all counts become zero.
                    state_d = c_ST_IDLE;
                end
            end
            c_ST_ALARM: begin
                if (!w_any_thr && w_ack_ok) begin
                    state_d     = c_ST_ACKED;
                    hold_cnt_d  = '0;
                    w_clr       = 1'b1;
                    ack_armed_d = 1'b0;
                end
            end
            c_ST_ACKED: begin
                if (w_any_thr) begin
                    state_d = c_ST_ALARM;
                end else if (hold_cnt_q == c_HOLD_LAST) begin
                    state_d = c_ST_IDLE;
                    flags_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            win_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            state_q     <= c_ST_IDLE;
            flags_q     <= '0;
            ack_armed_q <= 1'b0;
            alarm_q     <= 1'b0;
            warn_q      <= 1'b0;
        end else begin
            win_cnt_q   <= w_win_wrap ? '0 : (win_cnt_q + WIN_W'(1));
            hold_cnt_q  <= hold_cnt_d;
            state_q     <= state_d;
            flags_q     <= flags_d;
            ack_armed_q <= ack_armed_d;
            alarm_q     <= (state_d == c_ST_ALARM);
            warn_q      <= (state_d == c_ST_WARN);
        end
    end

    assign alarm     = alarm_q;
    assign warn      = warn_q;
    assign gas_flags = flags_q;
    assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_gas_alarm_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_gas_alarm_controller
// Brief  : Directed and randomized checks of gas_alarm_controller against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_gas_alarm_controller;

    localparam int WINDOW   = 64;
    localparam int THRESH   = 3;
    localparam int HOLD_CYC = 16;

    logic       clk;
    logic       arst;
    logic [2:0] det;
    logic       ack;
    logic       alarm;
    logic       warn;
    logic [2:0] gas_flags;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    // Behavioural model: window position, per-gas hit counts, state 0..3.
    int         m_win;
    int         m_hit [3];
    int         m_state;
    int         m_hold;
    logic [2:0] m_flags;
    bit         m_armed;

    gas_alarm_controller #(
        .WINDOW   (WINDOW),
        .THRESH   (THRESH),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .det       (det),
        .ack       (ack),
        .alarm     (alarm),
        .warn      (warn),
        .gas_flags (gas_flags),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_win   = 0;
        m_state = 0;
        m_hold  = 0;
        m_flags = 3'b000;
        m_armed = 1'b0;
        for (int g = 0; g < 3; g++) m_hit[g] = 0;
    endtask

    task automatic model_step(input logic [2:0] d, input logic a);
        bit       wrap;
        bit [2:0] thr;
        int       nh [3];
        int       ns, nhold;
        logic [2:0] nf;
        bit       narm;
        bit       all_zero;
        wrap = (m_win == WINDOW - 1);
        for (int g = 0; g < 3; g++) begin
            if (wrap) begin
                nh[g]  = d[g] ? 1 : 0;
                thr[g] = d[g] && (THRESH == 1);
            end else begin
                nh[g]  = (d[g] && m_hit[g] < THRESH) ? m_hit[g] + 1 : m_hit[g];
                thr[g] = (nh[g] != m_hit[g]) && (nh[g] == THRESH);
            end
        end
        all_zero = (nh[0] == 0) && (nh[1] == 0) && (nh[2] == 0);
        ns    = m_state;
        nhold = m_hold;
        nf    = m_flags | thr;
        narm  = a ? m_armed : 1'b1;
        case (m_state)
            0: if (thr != 0) ns = 2; else if (d != 0) ns = 1;
            1: if (thr != 0) ns = 2; else if (wrap && all_zero) ns = 0;
            2: if (thr == 0 && a && m_armed) begin
                   ns = 3; nhold = 0; narm = 1'b0;
                   for (int g = 0; g < 3; g++) nh[g] = 0;
               end
            default: if (thr != 0) ns = 2;
                     else if (m_hold == HOLD_CYC - 1) begin ns = 0; nf = 3'b000; end
                     else nhold = m_hold + 1;
        endcase
        for (int g = 0; g < 3; g++) m_hit[g] = nh[g];
        m_state = ns;
        m_hold  = nhold;
        m_flags = nf;
        m_armed = narm;
        m_win   = wrap ? 0 : m_win + 1;
    endtask

    // Drive one cycle of inputs, advance the model, and land 1 time unit after the edge.
    task automatic tick(input logic [2:0] d, input logic a);
        det = d;
        ack = a;
        model_step(d, a);
        @(posedge clk);
        #1;
    endtask

    task automatic goto_win(input int k);
        while (m_win != k) tick(3'b000, 1'b0);
    endtask

    task automatic apply_reset();
        arst = 1'b0;
        det  = 3'b000;
        ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        arst = 1'b0;
        det  = 3'b111;
        ack  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
        checks++; if (warn !== 1'b0) begin errors++; $display("FAIL reset_warn got=%b exp=0", warn); end
        checks++; if (gas_flags !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", gas_flags); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        det  = 3'b000;
        ack  = 1'b0;
        arst = 1'b1;
        model_reset();
        tick(3'b000, 1'b0);
        checks++; if (state !== 2'd0 || warn !== 1'b0) begin errors++; $display("FAIL reset_release state=%0d warn=%b exp state=0 warn=0", state, warn); end
    endtask

    task automatic test_warn();
        apply_reset();
        goto_win(5);
        tick(3'b010, 1'b0);
        checks++; if (warn !== 1'b1 || state !== 2'd1) begin errors++; $display("FAIL warn_set warn=%b state=%0d exp warn=1 state=1", warn, state); end
        goto_win(WINDOW - 1);
        checks++; if (warn !== 1'b1) begin errors++; $display("FAIL warn_hold_prewrap warn=%b exp=1", warn); end
        tick(3'b000, 1'b0);
        checks++; if (warn !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL warn_clear_wrap warn=%b state=%0d exp warn=0 state=0", warn, state); end
    endtask

    task automatic test_alarm();
        apply_reset();
        goto_win(10); tick(3'b001, 1'b0);
        goto_win(20); tick(3'b001, 1'b0);
        goto_win(30);
        checks++; if (alarm !== 1'b0 || state !== 2'd1) begin errors++; $display("FAIL alarm_pre alarm=%b state=%0d exp alarm=0 state=1", alarm, state); end
        tick(3'b001, 1'b0);
        checks++; if (alarm !== 1'b1 || gas_flags !== 3'b001 || state !== 2'd2) begin
            errors++; $display("FAIL alarm_third_hit alarm=%b flags=%b state=%0d exp 1 001 2", alarm, gas_flags, state);
        end
    endtask

    task automatic test_ack_hold();
        tick(3'b000, 1'b1);
        checks++; if (state !== 2'd3 || alarm !== 1'b0 || gas_flags !== 3'b001) begin
            errors++; $display("FAIL ack_enter state=%0d alarm=%b flags=%b exp 3 0 001", state, alarm, gas_flags);
        end
        repeat (HOLD_CYC - 1) tick(3'b000, 1'b0);
        checks++; if (state !== 2'd3 || gas_flags !== 3'b001) begin errors++; $display("FAIL ack_hold_last state=%0d flags=%b exp 3 001", state, gas_flags); end
        tick(3'b000, 1'b0);
        checks++; if (state !== 2'd0 || gas_flags !== 3'b000) begin errors++; $display("FAIL ack_release state=%0d flags=%b exp 0 000", state, gas_flags); end
    endtask

    task automatic test_window_wrap();
        apply_reset();
        goto_win(60); tick(3'b001, 1'b0);
        goto_win(62); tick(3'b001, 1'b0);
        goto_win(6);  tick(3'b001, 1'b0);
        checks++; if (alarm !== 1'b0 || state !== 2'd1 || gas_flags !== 3'b000) begin
            errors++; $display("FAIL wrap_no_alarm alarm=%b state=%0d flags=%b exp 0 1 000", alarm, state, gas_flags);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        goto_win(2);
        repeat (3) tick(3'b001, 1'b0);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL b2b_alarm state=%0d exp=2", state); end
        tick(3'b000, 1'b1);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL b2b_ack state=%0d exp=3", state); end
        repeat (3) tick(3'b100, 1'b1);
        checks++; if (state !== 2'd2 || alarm !== 1'b1 || gas_flags !== 3'b101) begin
            errors++; $display("FAIL b2b_realarm state=%0d alarm=%b flags=%b exp 2 1 101", state, alarm, gas_flags);
        end
        repeat (4) tick(3'b000, 1'b1);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL b2b_held_ack state=%0d exp=2", state); end
        tick(3'b000, 1'b0);
        tick(3'b000, 1'b1);
        checks++; if (state !== 2'd3 || gas_flags !== 3'b101) begin errors++; $display("FAIL b2b_reack state=%0d flags=%b exp 3 101", state, gas_flags); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        goto_win(2);
        repeat (3) tick(3'b010, 1'b0);
        checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL async_pre alarm=%b exp=1", alarm); end
        #3;
        arst = 1'b0;
        #1;
        checks++; if (alarm !== 1'b0 || state !== 2'd0 || gas_flags !== 3'b000) begin
            errors++; $display("FAIL async_drop alarm=%b state=%0d flags=%b exp 0 0 000", alarm, state, gas_flags);
        end
        @(posedge clk);
        #1;
        arst = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        logic [2:0] d;
        logic       a;
        logic [6:0] exp_v;
        logic [6:0] got_v;
        logic [1:0] st;
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int g = 0; g < 3; g++) d[g] = ($urandom_range(0, 9) == 0);
            a = ($urandom_range(0, 3) == 0);
            tick(d, a);
            st    = m_state[1:0];
            exp_v = {st, (m_state == 2), (m_state == 1), m_flags};
            got_v = {state, alarm, warn, gas_flags};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random_cycle%0d got{st,al,wr,fl}=%b exp=%b", c, got_v, exp_v);
            end
        end
    endtask

    initial begin
        arst = 1'b0;
        det  = 3'b000;
        ack  = 1'b0;
        model_reset();
        test_reset();
        test_warn();
        test_alarm();
        test_ack_hold();
        test_window_wrap();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gas_alarm_controller.md
Name: gas_alarm_controller

Overview:
- Downstream consumer of the three-bit gas detector vector (bit2 CO2, bit1 CO, bit0 methane).
- Counts detection pulses per gas inside a fixed observation window and raises a warning on any hit.
- Raises a latched, acknowledge-able alarm when any gas reaches a hit threshold within one window.
- Drives the panel/buzzer interface of the gas engine utilities.

Parameters:
- WINDOW, 64: observation window length in clk cycles (≥2).
- THRESH, 3: hits within one window that trigger an alarm for that gas (1..15).
- HOLD_CYC, 16: cycles spent in ACKED before returning to IDLE (≥1).

Ports:
- clk  input  1  clock; all logic on posedge.
- arst  input  1  asynchronous reset, active-low.
- det  input  3  detector flags, one bit per gas; each high cycle counts as one hit.
- ack  input  1  operator acknowledge, level-sampled each cycle.
- alarm  output  1  high while in ALARM.
- warn  output  1  high while in WARN.
- gas_flags  output  3  sticky per-gas alarm flags.
- state  output  2  encoded FSM state: IDLE=0, WARN=1, ALARM=2, ACKED=3.

Behaviour:
- Reset (arst low, asynchronous): all registers zero.
  - Outputs: alarm=0, warn=0, gas_flags=000, state=IDLE.
  - Counters: win_cnt=0, hit_cnt[g]=0, hold_cnt=0.
- win_cnt free-runs 0..WINDOW-1, then wraps to 0.
- The wrap cycle is the cycle where win_cnt==WINDOW-1. On that cycle each hit_cnt[g] loads det[g] (0 or 1), not 0.
- Other cycles: hit_cnt[g] increments when det[g]=1. It saturates at THRESH.
- Threshold event thr[g] is combinational: det[g]=1 and the next hit_cnt[g] equals THRESH while the current value is below THRESH.
  - On the wrap cycle with THRESH=1, det[g]=1 also fires thr[g].
- gas_flags[g] sets on the clock after thr[g]. It stays set until cleared by the FSM.
- Multiple gases may cross threshold in the same cycle; all of their flags set.
- FSM, evaluated every cycle in priority order:
  - IDLE: any thr → ALARM; else any det → WARN.
  - WARN: any thr → ALARM; else if all hit_cnt==0 after the wrap → IDLE.
  - ALARM: ack=1 → ACKED. Ignore ack if thr is asserted in the same cycle; stay in ALARM and set the new flags.
  - ACKED: any thr → ALARM (new flags OR into existing ones); else when hold_cnt reaches HOLD_CYC-1 → IDLE.
- On entry to ACKED:
  - hold_cnt=0 and all hit_cnt cleared. This clear overrides the increment for that cycle.
  - gas_flags are retained for display.
- On the ACKED→IDLE transition: gas_flags cleared to 000.
- ack held high continuously has no effect outside ALARM.
- A held ack does not re-acknowledge after ACKED→ALARM until ack has been low for at least one cycle (edge-qualified through an ack_armed register).
- Output timing:
  - alarm/warn/state are registered decodes of the state. They change one cycle after the triggering input.
  - Latency: det pulse to alarm is 1 cycle for the THRESH-th hit.
- An asynchronous reset mid-ALARM drops alarm immediately, without waiting for a clock edge.
- Width rules:
  - hit counters: clog2(THRESH+1) bits.
  - win_cnt: clog2(WINDOW) bits.
  - hold_cnt: clog2(HOLD_CYC) bits (minimum 1).

Decomposition:
- Shared package gas_pkg:
  - state encoding constants.
  - gas index constants GAS_CO2=2, GAS_CO=1, GAS_CH4=0.
  - NUM_GAS=3.
- Natural sub-module: gas_hit_counter.
  - One instance per gas (window-relative saturating counter plus thr output).
  - Inputs: win_wrap, clr, det.

Test Plan:
- Reset check: hold arst low with det=111, ack=1 → alarm=0, warn=0, gas_flags=000, state=0. Release reset → IDLE on the first clock.
- Single CO pulse at cycle 5 → warn=1 from cycle 6. After the next wrap with no hits → state=IDLE, warn=0.
- Methane pulses at cycles 10, 20, 30 (THRESH=3, WINDOW=64) → alarm=1 at cycle 31, gas_flags=001, state=2.
- Methane pulses at cycles 60, 62 and 70 → no alarm. The window wrap at 63 resets the count to 0, so the final count is 1.
- ALARM, then ack=1 for one cycle → state=3, alarm=0, flags kept. Exactly 16 cycles later → IDLE, gas_flags=000.
- ALARM with ack held high, then CO2 hits 3 times in ACKED → return to ALARM, gas_flags=101. Held ack does not re-acknowledge until ack has gone low and then high again.
